// File: rtl/mech_detune_sum.sv
// rtl/mech_detune_sum.sv - sums enabled mechanical mode positions per frame into a saturated cavity detune word
module mech_detune_sum #(
    parameter int n_mech_modes = 7,
    parameter int sample_phase = 0,
    parameter int shift        = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_eig,
    input  logic signed [17:0]       mech_x,
    input  logic [n_mech_modes-1:0]  mode_en,
    input  logic                     clip_clr,
    output logic signed [17:0]       detune,
    output logic                     detune_valid,
    output logic                     sum_clip,
    output logic                     frame_err
);

    localparam int SW = $clog2(2 * n_mech_modes);
    localparam int AW = 18 + $clog2(n_mech_modes) + 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(2 * n_mech_modes - 1);
    localparam logic PHASE = 1'(sample_phase);
    localparam logic signed [AW-1:0] SAT_MAX = AW'(131071);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-131072);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         slot_q, slot_d, slot_c;
    logic signed [AW-1:0]  acc_q, acc_d, acc_base, x_ext, acc_shr, acc_sat;
    logic [SW-2:0]         mode_idx;
    logic                  run, last, early, sample, clip_hit;

    // start_eig overrides the counter so the marker cycle itself is slot 0
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        slot_c  = slot_q;
        run     = 1'b0;
        last    = 1'b0;
        early   = 1'b0;
        if (start_eig) begin
            run    = 1'b1;
            slot_c = '0;
            early  = (state_q == RUN) && (slot_q < LAST_SLOT);
        end else if (state_q == RUN) begin
            run = 1'b1;
        end
        if (run) begin
            if (slot_c == LAST_SLOT) begin
                last    = 1'b1;
                state_d = IDLE;
                slot_d  = slot_c;
            end else begin
                state_d = RUN;
                slot_d  = slot_c + SW'(1);
            end
        end
    end

    // slot 0 reloads the accumulator, so back-to-back frames need no clear cycle
    always_comb begin
        mode_idx = slot_c[SW-1:1];
        sample   = run && (slot_c[0] == PHASE) && mode_en[mode_idx];
        x_ext    = {{(AW-18){mech_x[17]}}, mech_x};
        acc_base = (slot_c == '0) ? '0 : acc_q;
        acc_d    = acc_q;
        if (run) begin
            acc_d = sample ? acc_base + x_ext : acc_base;
        end
        acc_shr  = acc_d >>> shift;
        clip_hit = (acc_shr > SAT_MAX) || (acc_shr < SAT_MIN);
        if (acc_shr > SAT_MAX) begin
            acc_sat = SAT_MAX;
        end else if (acc_shr < SAT_MIN) begin
            acc_sat = SAT_MIN;
        end else begin
            acc_sat = acc_shr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            acc_q        <= '0;
            detune       <= '0;
            detune_valid <= 1'b0;
            sum_clip     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            acc_q        <= acc_d;
            detune_valid <= last;
            if (last) begin
                detune <= acc_sat[17:0];
            end
            // a new event in the same cycle as clip_clr keeps the flag set
            sum_clip  <= (last && clip_hit) || (sum_clip && !clip_clr);
            frame_err <= early || (frame_err && !clip_clr);
        end
    end

endmodule
